// File: rtl/onewire_pkg.sv
// Shared state encoding and default bus timing for the 1-Wire slave bit engine.
package onewire_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SLOT,
    WAIT_HIGH,
    PRES_WAIT,
    PRES_LOW,
    PRES_REL
  } onewire_slave_state_t;

  localparam int unsigned DEF_CLKS_PER_US = 50;
  localparam int unsigned DEF_T_SAMPLE_US = 30;
  localparam int unsigned DEF_T_RESET_US  = 480;
  localparam int unsigned DEF_T_PDH_US    = 30;
  localparam int unsigned DEF_T_PDL_US    = 120;

endpackage

// File: rtl/onewire_us_tick.sv
// Microsecond prescaler; clr realigns the tick phase to a timing restart.
module onewire_us_tick #(
  parameter int unsigned CLKS_PER_US = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_US - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST) && !clr;

endmodule

// File: rtl/onewire_slave_bit.sv
// 1-Wire slave bit layer: write-slot sampling, read-slot drive, reset detect and presence pulse.
module onewire_slave_bit
  import onewire_pkg::*;
#(
  parameter int unsigned CLKS_PER_US = DEF_CLKS_PER_US,
  parameter int unsigned T_SAMPLE_US = DEF_T_SAMPLE_US,
  parameter int unsigned T_RESET_US  = DEF_T_RESET_US,
  parameter int unsigned T_PDH_US    = DEF_T_PDH_US,
  parameter int unsigned T_PDL_US    = DEF_T_PDL_US
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dq_in,
  output logic dq_out_en,
  input  logic mode,
  input  logic tx_bit,
  input  logic tx_valid,
  output logic tx_done,
  output logic rx_bit,
  output logic rx_valid,
  output logic reset_det,
  output logic busy
);

  localparam int unsigned CW = $clog2(T_RESET_US + 1);
  localparam logic [CW-1:0] C_SAMPLE = CW'(T_SAMPLE_US);
  localparam logic [CW-1:0] C_RESET  = CW'(T_RESET_US);
  localparam logic [CW-1:0] C_PDH    = CW'(T_PDH_US);
  localparam logic [CW-1:0] C_PDL    = CW'(T_PDL_US);

  onewire_slave_state_t state;
  logic [CW-1:0] cnt;
  logic sync1, sync2, sync3;
  logic fall;
  logic restart;
  logic tick;
  logic mode_q;
  logic slot_tx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= dq_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign fall = sync3 & ~sync2;

  // Every point that zeroes the us counter also realigns the prescaler phase.
  always_comb begin
    restart = 1'b0;
    case (state)
      IDLE:      restart = fall;
      WAIT_HIGH: restart = sync2 && (cnt == C_RESET);
      PRES_WAIT: restart = (cnt == C_PDH);
      default:   restart = 1'b0;
    endcase
  end

  onewire_us_tick #(
    .CLKS_PER_US(CLKS_PER_US)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (restart),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_q    <= 1'b0;
      slot_tx   <= 1'b0;
      dq_out_en <= 1'b0;
      rx_bit    <= 1'b0;
      rx_valid  <= 1'b0;
      tx_done   <= 1'b0;
      reset_det <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      tx_done   <= 1'b0;
      reset_det <= 1'b0;

      if (restart) begin
        cnt <= '0;
      end else if (tick && cnt != C_RESET) begin
        cnt <= cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          dq_out_en <= 1'b0;
          if (fall) begin
            state     <= SLOT;
            mode_q    <= mode;
            slot_tx   <= mode & tx_valid;
            dq_out_en <= mode & tx_valid & ~tx_bit;
          end
        end
        SLOT: begin
          if (cnt == C_SAMPLE) begin
            state     <= WAIT_HIGH;
            dq_out_en <= 1'b0;
            if (!mode_q) begin
              rx_bit   <= sync2;
              rx_valid <= 1'b1;
            end else if (slot_tx && tx_valid) begin
              tx_done <= 1'b1;
            end
          end else begin
            // Withdrawing tx_valid mid-slot releases the line and forfeits tx_done.
            dq_out_en <= mode_q & tx_valid & ~tx_bit;
            slot_tx   <= slot_tx & tx_valid;
          end
        end
        WAIT_HIGH: begin
          // Level test: the master may already have released while SLOT ran on.
          if (sync2) begin
            if (cnt == C_RESET) begin
              state     <= PRES_WAIT;
              reset_det <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        PRES_WAIT: begin
          if (cnt == C_PDH) begin
            state     <= PRES_LOW;
            dq_out_en <= 1'b1;
          end
        end
        PRES_LOW: begin
          if (cnt == C_PDL) begin
            state     <= PRES_REL;
            dq_out_en <= 1'b0;
          end
        end
        PRES_REL: begin
          dq_out_en <= 1'b0;
          if (sync2) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          dq_out_en <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_onewire_slave_bit.sv
// Directed and randomized 1-Wire slots against a timing-rule model of the slave.
module tb_onewire_slave_bit;

  localparam int unsigned CPU  = 4;
  localparam int unsigned TS   = 30;
  localparam int unsigned TR   = 480;
  localparam int unsigned TPDH = 30;
  localparam int unsigned TPDL = 120;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dq_in;
  logic dq_out_en;
  logic mode = 1'b0;
  logic tx_bit = 1'b1;
  logic tx_valid = 1'b0;
  logic tx_done;
  logic rx_bit;
  logic rx_valid;
  logic reset_det;
  logic busy;
  logic master_low = 1'b0;

  // Open-drain bus: low if either side pulls.
  assign dq_in = ~(master_low | dq_out_en);

  always #5 clk = ~clk;

  onewire_slave_bit #(
    .CLKS_PER_US(CPU),
    .T_SAMPLE_US(TS),
    .T_RESET_US (TR),
    .T_PDH_US   (TPDH),
    .T_PDL_US   (TPDL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dq_in    (dq_in),
    .dq_out_en(dq_out_en),
    .mode     (mode),
    .tx_bit   (tx_bit),
    .tx_valid (tx_valid),
    .tx_done  (tx_done),
    .rx_bit   (rx_bit),
    .rx_valid (rx_valid),
    .reset_det(reset_det),
    .busy     (busy)
  );

  int checks = 0;
  int failures = 0;

  int t, rel_t, rx_n, rx_t, txd_n, rd_n, rd_t, drv_n, pres_t;
  logic rxb;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int v, input int lo, input int hi);
    checks++;
    assert (v >= lo && v <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=[%0d..%0d]", tag, v, lo, hi);
    end
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
    t++;
    if (rx_valid === 1'b1) begin
      rx_n++;
      rx_t = t;
      rxb  = rx_bit;
    end
    if (tx_done === 1'b1) begin
      txd_n++;
      tx_valid = 1'b0;
    end
    if (reset_det === 1'b1) begin
      rd_n++;
      rd_t = t;
    end
    if (dq_out_en === 1'b1) begin
      drv_n++;
      if (t > rel_t && pres_t < 0) pres_t = t;
    end
  endtask

  // Master holds the line low for len_us, then the slave's reaction is scored.
  task automatic run_slot(input string name, input int len_us, input logic m,
                          input logic tv, input logic tb);
    bit exp_reset, exp_rx, exp_txd;
    int drive_us;
    t = 0; rel_t = 1 << 30; rx_n = 0; rx_t = -1; txd_n = 0; rd_n = 0; rd_t = -1;
    drv_n = 0; pres_t = -1; rxb = 1'bx;
    mode = m; tx_valid = tv; tx_bit = tb;
    master_low = 1'b1;
    repeat (len_us * CPU) sample();
    master_low = 1'b0;
    rel_t = t;
    for (int i = 0; i < 1000 * int'(CPU); i++) begin
      sample();
      if (busy === 1'b0 && dq_in === 1'b1) break;
    end
    check_eq({name, " idle"}, busy, 0);
    repeat (8) sample();
    tx_valid = 1'b0;

    exp_reset = (len_us >= int'(TR));
    exp_rx    = !m;
    exp_txd   = m && tv;
    drive_us  = ((m && tv && !tb) ? TS : 0) + (exp_reset ? TPDL : 0);

    check_eq({name, " rx_count"}, rx_n, exp_rx ? 1 : 0);
    if (exp_rx) begin
      check_eq({name, " rx_bit"}, rxb, (len_us < int'(TS)) ? 1 : 0);
      check_rng({name, " rx_time"}, rx_t, TS * CPU - 4, TS * CPU + 8);
    end
    check_eq({name, " tx_done_count"}, txd_n, exp_txd ? 1 : 0);
    check_eq({name, " reset_det_count"}, rd_n, exp_reset ? 1 : 0);
    check_rng({name, " drive_cycles"}, drv_n, drive_us * CPU - 6, drive_us * CPU + 6);
    if (exp_reset) begin
      check_rng({name, " reset_det_delay"}, rd_t - rel_t, 1, 8);
      check_rng({name, " presence_delay"}, pres_t - rel_t, TPDH * CPU - 2, TPDH * CPU + 10);
    end
  endtask

  initial begin
    int len, sel;
    logic rm, rtv, rtb;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst dq_out_en", dq_out_en, 0);
    check_eq("rst busy", busy, 0);
    check_eq("rst rx_valid", rx_valid, 0);
    check_eq("rst tx_done", tx_done, 0);
    check_eq("rst reset_det", reset_det, 0);
    check_eq("rst rx_bit", rx_bit, 0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    run_slot("rx_one_10us", 10, 1'b0, 1'b0, 1'b1);
    run_slot("rx_zero_65us", 65, 1'b0, 1'b0, 1'b1);
    run_slot("tx_zero_2us", 2, 1'b1, 1'b1, 1'b0);
    run_slot("tx_one_2us", 2, 1'b1, 1'b1, 1'b1);
    run_slot("tx_novalid", 2, 1'b1, 1'b0, 1'b0);
    run_slot("bus_reset_500us", 500, 1'b0, 1'b0, 1'b1);
    run_slot("long_470us", 470, 1'b0, 1'b0, 1'b1);
    run_slot("reset_after_tx0", 510, 1'b1, 1'b1, 1'b0);

    for (int n = 0; n < 10; n++) begin
      sel = int'($urandom_range(0, 2));
      if (sel == 0)      len = int'($urandom_range(1, 26));
      else if (sel == 1) len = int'($urandom_range(34, 460));
      else               len = int'($urandom_range(490, 560));
      rm  = 1'($urandom_range(0, 1));
      rtv = 1'($urandom_range(0, 1));
      rtb = 1'($urandom_range(0, 1));
      run_slot($sformatf("rand%0d_len%0d_m%0d", n, len, rm), len, rm, rtv, rtb);
    end

    // Reset asserted in the middle of the presence pulse.
    master_low = 1'b1;
    repeat (500 * CPU) @(posedge clk);
    #1;
    master_low = 1'b0;
    for (int i = 0; i < 200 * int'(CPU); i++) begin
      @(posedge clk);
      #1;
      if (dq_out_en === 1'b1) break;
    end
    check_eq("pres_started", dq_out_en, 1);
    repeat (50 * CPU) @(posedge clk);
    #1;
    check_eq("pres_mid_drive", dq_out_en, 1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst dq_out_en", dq_out_en, 0);
    check_eq("async_rst busy", busy, 0);
    check_eq("async_rst reset_det", reset_det, 0);
    #30;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("post_rst idle", busy, 0);
    run_slot("post_rst_rx", 5, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
